// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order front end: opcodes, decoded control bits,
// buffered instruction entries and the dispatch issue payload.
package ooo_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned IMM_W = 16;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HALT = 6'b110001;

  typedef struct packed {
    logic is_dispatch;
    logic write_rd;
    logic reg_dest;
    logic mem_wen;
    logic mem_ren;
    logic read_rs;
    logic read_rt;
  } dec_ctrl_t;

  typedef struct packed {
    logic [5:0]       opcode;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    dec_ctrl_t        ctrl;
  } fifo_entry_t;

  typedef struct packed {
    logic [5:0]       opcode;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dst;
    logic [IMM_W-1:0] imm;
    logic             dst_en;
    logic             mem_wen;
    logic             mem_ren;
  } issue_payload_t;

  // Loads and stores go to the LSQ, everything else to the ALU RS.
  function automatic logic is_mem_op(dec_ctrl_t c);
    return c.mem_wen | c.mem_ren;
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Small in-order instruction buffer with push/pop/flush; depth must be a
// power of two so the pointers wrap naturally.
module dispatch_fifo
  import ooo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1,
  parameter type         entry_t    = fifo_entry_t
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  entry_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push;
  logic               do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  always_comb begin
    do_pop     = pop & (count_q != '0);
    do_push    = push & (count_q != CNT_W'(FIFO_DEPTH));
    head_valid = (count_q != '0);
    head       = mem_q[rd_ptr_q];
    count      = count_q;
  end

  // Storage, pointers and occupancy; flush drops every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/dispatch_unit.sv
// In-order dispatch stage: buffers decoded instructions, checks RAW/WAW hazards
// against a register busy scoreboard and issues to the ALU RS or the LSQ.
// Optional macro DISPATCH_CDB_BYPASS_EN lets a consumer issue in the same
// cycle as the CDB broadcast that clears its source/destination register.
module dispatch_unit #(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned REG_W       = 5,
  parameter int unsigned IMM_W       = 16,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [5:0]             in_opcode,
  input  logic [REG_W-1:0]       in_rs,
  input  logic [REG_W-1:0]       in_rt,
  input  logic [REG_W-1:0]       in_rd,
  input  logic [IMM_W-1:0]       in_imm,
  input  logic                   in_is_dispatch,
  input  logic                   in_write_rd,
  input  logic                   in_reg_dest,
  input  logic                   in_mem_wen,
  input  logic                   in_mem_ren,
  input  logic                   in_read_rs,
  input  logic                   in_read_rt,
  input  logic                   cdb_valid,
  input  logic [REG_W-1:0]       cdb_reg,
  output logic                   alu_valid,
  input  logic                   alu_ready,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [5:0]             out_opcode,
  output logic [REG_W-1:0]       out_rs,
  output logic [REG_W-1:0]       out_rt,
  output logic [REG_W-1:0]       out_dst,
  output logic [IMM_W-1:0]       out_imm,
  output logic                   out_dst_en,
  output logic                   out_mem_wen,
  output logic                   out_mem_ren,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  import ooo_pkg::*;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e                   state_q;
  logic                     halted_q;
  logic                     rdy_q;
  logic [NUM_REGS-1:0]      busy_q;
  logic [NUM_REGS-1:0]      busy_d;
  logic [STALL_CNT_W-1:0]   stall_q;

  fifo_entry_t              in_entry;
  fifo_entry_t              head;
  logic                     head_valid;
  logic [CNT_W-1:0]         count;
  logic                     push;
  logic                     pop;

  logic [REG_W-1:0]         dst;
  logic                     dst_en;
  logic                     to_mem;
  logic                     run;
  logic [NUM_REGS-1:0]      cdb_dec;
  logic [NUM_REGS-1:0]      busy_eff;
  logic                     haz;
  logic                     issue;
  logic                     stall_inc;
  issue_payload_t           payload;

  // Pack the decoder fields into a buffer entry.
  always_comb begin
    in_entry                  = '0;
    in_entry.opcode           = in_opcode;
    in_entry.rs               = in_rs;
    in_entry.rt               = in_rt;
    in_entry.rd               = in_rd;
    in_entry.imm              = in_imm;
    in_entry.ctrl.is_dispatch = in_is_dispatch;
    in_entry.ctrl.write_rd    = in_write_rd;
    in_entry.ctrl.reg_dest    = in_reg_dest;
    in_entry.ctrl.mem_wen     = in_mem_wen;
    in_entry.ctrl.mem_ren     = in_mem_ren;
    in_entry.ctrl.read_rs     = in_read_rs;
    in_entry.ctrl.read_rt     = in_read_rt;
  end

  dispatch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W),
    .entry_t    (fifo_entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push),
    .push_data  (in_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  // Head decode, hazard detection, issue handshake and input acceptance.
  always_comb begin
    run    = (state_q == StRun);
    dst    = head.ctrl.write_rd ? head.rd : head.rt;
    dst_en = head.ctrl.reg_dest & (dst != '0);
    to_mem = is_mem_op(head.ctrl);

    cdb_dec          = '0;
    cdb_dec[cdb_reg] = cdb_valid;
`ifdef DISPATCH_CDB_BYPASS_EN
    busy_eff = busy_q & ~cdb_dec;
`else
    busy_eff = busy_q;
`endif
    busy_eff[0] = 1'b0;

    haz = (head.ctrl.read_rs & busy_eff[head.rs]) |
          (head.ctrl.read_rt & busy_eff[head.rt]) |
          (dst_en & busy_eff[dst]);

    issue     = head_valid & head.ctrl.is_dispatch & ~haz & run & ~flush;
    alu_valid = issue & ~to_mem;
    mem_valid = issue & to_mem;
    stall_inc = head_valid & head.ctrl.is_dispatch & haz;

    // Non-dispatch heads retire silently; dispatch heads retire on handshake.
    if (head.ctrl.is_dispatch) pop = (alu_valid & alu_ready) | (mem_valid & mem_ready);
    else                       pop = head_valid & run & ~flush;

    in_ready = rdy_q & (count < CNT_W'(FIFO_DEPTH)) & run & ~flush;
    push     = in_valid & in_ready;
  end

  // Issue payload comes straight from the head; zero when the buffer is empty.
  always_comb begin
    payload = '0;
    if (head_valid) begin
      payload.opcode  = head.opcode;
      payload.rs      = head.rs;
      payload.rt      = head.rt;
      payload.dst     = dst;
      payload.imm     = head.imm;
      payload.dst_en  = dst_en;
      payload.mem_wen = head.ctrl.mem_wen;
      payload.mem_ren = head.ctrl.mem_ren;
    end
    out_opcode  = payload.opcode;
    out_rs      = payload.rs;
    out_rt      = payload.rt;
    out_dst     = payload.dst;
    out_imm     = payload.imm;
    out_dst_en  = payload.dst_en;
    out_mem_wen = payload.mem_wen;
    out_mem_ren = payload.mem_ren;
    halted      = halted_q;
    stall_cnt   = stall_q;
  end

  // Scoreboard next state: CDB clears first so a new producer of the same reg wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d = busy_d & ~cdb_dec;
      if (pop & head.ctrl.is_dispatch & dst_en) busy_d[dst] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy bits register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Run/halt FSM with registered halted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      halted_q <= 1'b0;
    end else if (flush) begin
      state_q  <= StRun;
      halted_q <= 1'b0;
    end else if (run && pop && head.opcode == OP_HALT) begin
      state_q  <= StHalted;
      halted_q <= 1'b1;
    end
  end

  // Hold in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  // Saturating hazard-stall counter; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        stall_q <= '0;
    else if (stall_inc && stall_q != '1) stall_q <= stall_q + STALL_CNT_W'(1);
  end

endmodule

// File: tb/tb_dispatch_unit.sv
// Self-checking bench for dispatch_unit: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_dispatch_unit;

`ifdef DISPATCH_CDB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam logic [5:0] HALT = 6'b110001;
  localparam int STALL_MAX = 65535;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        disp, wrd, rdest, wen, ren, rrs, rrt;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rs, in_rt, in_rd, cdb_reg;
  logic [15:0] in_imm;
  logic        in_is_dispatch, in_write_rd, in_reg_dest, in_mem_wen, in_mem_ren;
  logic        in_read_rs, in_read_rt, cdb_valid;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs, out_rt, out_dst;
  logic [15:0] out_imm, stall_cnt;
  logic        out_dst_en, out_mem_wen, out_mem_ren, halted;

  always #5 clk = ~clk;

  dispatch_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_is_dispatch(in_is_dispatch), .in_write_rd(in_write_rd), .in_reg_dest(in_reg_dest),
    .in_mem_wen(in_mem_wen), .in_mem_ren(in_mem_ren), .in_read_rs(in_read_rs),
    .in_read_rt(in_read_rt), .cdb_valid(cdb_valid), .cdb_reg(cdb_reg),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
    .out_dst(out_dst), .out_imm(out_imm), .out_dst_en(out_dst_en),
    .out_mem_wen(out_mem_wen), .out_mem_ren(out_mem_ren), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  // Reference model state.
  instr_t mq[$];
  bit     mbusy[32];
  bit     mhalted, mrdy;
  int     mstall;
  bit     e_pop, e_push, e_set, e_inc, e_halt;
  int     e_dst;
  instr_t e_in;

  int checks = 0;
  int errors = 0;

  function automatic instr_t mk(logic [5:0] op, int rs, int rt, int rd, logic [15:0] imm,
                                bit disp, bit wrd, bit rdest, bit wen, bit ren,
                                bit rrs, bit rrt);
    instr_t i;
    i.op = op; i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd); i.imm = imm;
    i.disp = disp; i.wrd = wrd; i.rdest = rdest; i.wen = wen; i.ren = ren;
    i.rrs = rrs; i.rrt = rrt;
    return i;
  endfunction

  task automatic drive(input instr_t i, input bit v);
    in_valid = v; in_opcode = i.op; in_rs = i.rs; in_rt = i.rt; in_rd = i.rd;
    in_imm = i.imm; in_is_dispatch = i.disp; in_write_rd = i.wrd; in_reg_dest = i.rdest;
    in_mem_wen = i.wen; in_mem_ren = i.ren; in_read_rs = i.rrs; in_read_rt = i.rrt;
  endtask

  function automatic bit mb(int r);
    return r != 0 && mbusy[r] && !(BYPASS && cdb_valid && int'(cdb_reg) == r);
  endfunction

  task automatic model_reset();
    mq.delete();
    foreach (mbusy[r]) mbusy[r] = 1'b0;
    mhalted = 1'b0; mrdy = 1'b0; mstall = 0;
  endtask

  // Expected outputs for the current cycle, from the model state and live inputs.
  task automatic model_eval(output logic [59:0] exp);
    instr_t h;
    bit hv, haz, run, iss, ism, av, mv, den, rdy;
    logic [4:0] d;
    hv  = mq.size() > 0;
    h   = hv ? mq[0] : '0;
    d   = h.wrd ? h.rd : h.rt;
    den = h.rdest && d != 0;
    haz = (h.rrs && mb(h.rs)) || (h.rrt && mb(h.rt)) || (den && mb(d));
    run = !mhalted;
    iss = hv && h.disp && !haz && run && !flush;
    ism = h.wen || h.ren;
    av  = iss && !ism;
    mv  = iss && ism;
    e_pop  = hv && run && !flush && (h.disp ? ((av && alu_ready) || (mv && mem_ready)) : 1'b1);
    rdy    = mrdy && mq.size() < 2 && run && !flush;
    e_push = in_valid && rdy;
    e_set  = e_pop && h.disp && den;
    e_dst  = d;
    e_inc  = hv && h.disp && haz;
    e_halt = e_pop && h.op == HALT;
    e_in   = mk(in_opcode, in_rs, in_rt, in_rd, in_imm, in_is_dispatch, in_write_rd,
                in_reg_dest, in_mem_wen, in_mem_ren, in_read_rs, in_read_rt);
    exp = {rdy, av, mv, hv ? h.op : 6'd0, hv ? h.rs : 5'd0, hv ? h.rt : 5'd0,
           hv ? d : 5'd0, hv ? h.imm : 16'd0, hv && den, hv && h.wen, hv && h.ren,
           mhalted, 16'(mstall)};
  endtask

  task automatic model_update();
    if (flush) begin
      mq.delete();
      foreach (mbusy[r]) mbusy[r] = 1'b0;
      mhalted = 1'b0;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (e_push) mq.push_back(e_in);
      if (cdb_valid) mbusy[cdb_reg] = 1'b0;
      if (e_set) mbusy[e_dst] = 1'b1;
      if (e_halt) mhalted = 1'b1;
    end
    if (e_inc && mstall < STALL_MAX) mstall++;
    mrdy = 1'b1;
  endtask

  // One clock: compare all outputs mid-cycle, then advance DUT and model.
  task automatic tick(input string tag);
    logic [59:0] exp, act;
    #2;
    model_eval(exp);
    act = {in_ready, alu_valid, mem_valid, out_opcode, out_rs, out_rt, out_dst, out_imm,
           out_dst_en, out_mem_wen, out_mem_ren, halted, stall_cnt};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s outputs got=%h want=%h", tag, act, exp);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    drive('0, 1'b0);
    flush = 1'b0; cdb_valid = 1'b0; cdb_reg = '0; alu_ready = 1'b1; mem_ready = 1'b1;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick("flush"); flush = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    logic [59:0] act;
    act = {in_ready, alu_valid, mem_valid, out_opcode, out_rs, out_rt, out_dst, out_imm,
           out_dst_en, out_mem_wen, out_mem_ren, halted, stall_cnt};
    checks++;
    if (act !== 60'd0) begin
      errors++;
      $display("FAIL %s in reset got=%h want=0", tag, act);
    end
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick("post_release");
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release got=%b want=1", in_ready);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #13;
    check_all_zero("reset");
    release_reset();
  endtask

  task automatic test_alu_issue();
    do_flush();
    drive(mk(6'b000001, 1, 2, 3, 16'h0, 1, 1, 1, 0, 0, 1, 1), 1'b1);
    tick("add_accept");
    drive('0, 1'b0);
    #1;
    checks++;
    if (alu_valid !== 1'b1 || out_dst !== 5'd3 || out_dst_en !== 1'b1 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_issue got v=%b dst=%0d en=%b want v=1 dst=3 en=1", alu_valid,
               out_dst, out_dst_en);
    end
    tick("add_issue");
  endtask

  task automatic test_raw_stall();
    int s0;
    do_flush();
    s0 = mstall;
    drive(mk(6'b000001, 1, 2, 3, 16'h0, 1, 1, 1, 0, 0, 1, 1), 1'b1);
    tick("raw_add");
    drive(mk(6'b000010, 3, 1, 4, 16'h0, 1, 1, 1, 0, 0, 1, 1), 1'b1);
    tick("raw_sub_push");
    drive('0, 1'b0);
    for (int i = 0; i < 3; i++) tick("raw_stall");
    cdb_valid = 1'b1; cdb_reg = 5'd3;
    #1;
    checks++;
    if (alu_valid !== BYPASS) begin
      errors++;
      $display("FAIL raw_cdb_cycle alu_valid got=%b want=%b", alu_valid, BYPASS);
    end
    tick("raw_cdb");
    cdb_valid = 1'b0;
    #1;
    checks++;
    if (alu_valid !== !BYPASS || stall_cnt !== 16'(s0 + (BYPASS ? 3 : 4))) begin
      errors++;
      $display("FAIL raw_after_cdb got v=%b stall=%0d want v=%b stall=%0d", alu_valid,
               stall_cnt, !BYPASS, s0 + (BYPASS ? 3 : 4));
    end
    tick("raw_after");
  endtask

  task automatic test_mem_backpressure();
    do_flush();
    mem_ready = 1'b0;
    drive(mk(6'b100011, 1, 5, 0, 16'h0040, 1, 0, 1, 0, 1, 1, 0), 1'b1);
    tick("lw_accept");
    drive('0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mem_valid !== 1'b1 || alu_valid !== 1'b0 || out_dst !== 5'd5 ||
          out_imm !== 16'h0040 || out_mem_ren !== 1'b1) begin
        errors++;
        $display("FAIL lw_hold got mv=%b av=%b dst=%0d imm=%h want mv=1 av=0 dst=5 imm=0040",
                 mem_valid, alu_valid, out_dst, out_imm);
      end
      tick("lw_hold");
    end
    mem_ready = 1'b1;
    tick("lw_pop");
    #1;
    checks++;
    if (mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL lw_popped mem_valid got=%b want=0", mem_valid);
    end
  endtask

  task automatic test_nop_r0();
    do_flush();
    drive(mk(6'b000000, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    tick("nop_push");
    drive(mk(6'b001000, 1, 0, 0, 16'h0007, 1, 0, 1, 0, 0, 1, 0), 1'b1);
    #1;
    checks++;
    if (alu_valid !== 1'b0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL nop_silent got av=%b mv=%b want 0 0", alu_valid, mem_valid);
    end
    tick("addi_push");
    drive('0, 1'b0);
    #1;
    checks++;
    if (alu_valid !== 1'b1 || out_dst_en !== 1'b0 || out_imm !== 16'h0007) begin
      errors++;
      $display("FAIL addi_r0 got av=%b en=%b imm=%h want 1 0 0007", alu_valid, out_dst_en,
               out_imm);
    end
    tick("addi_issue");
  endtask

  task automatic test_halt_flush();
    do_flush();
    drive(mk(HALT, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    tick("halt_push");
    drive(mk(6'b000001, 1, 2, 7, 16'h0, 1, 1, 1, 0, 0, 1, 1), 1'b1);
    tick("halt_pop");
    drive('0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (halted !== 1'b1 || in_ready !== 1'b0 || alu_valid !== 1'b0 || out_dst !== 5'd7) begin
        errors++;
        $display("FAIL halted_hold got h=%b rdy=%b av=%b dst=%0d want 1 0 0 7", halted,
                 in_ready, alu_valid, out_dst);
      end
      tick("halted");
    end
    do_flush();
    #1;
    checks++;
    if (in_ready !== 1'b1 || halted !== 1'b0 || alu_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_flush got rdy=%b h=%b av=%b want 1 0 0", in_ready, halted, alu_valid);
    end
    tick("post_flush");
  endtask

  task automatic test_full_reset();
    do_flush();
    drive(mk(6'b000001, 1, 2, 3, 16'h0, 1, 1, 1, 0, 0, 1, 1), 1'b1);
    tick("full_add");
    drive(mk(6'b000010, 3, 1, 4, 16'h0, 1, 1, 1, 0, 0, 1, 1), 1'b1);
    tick("full_sub1");
    drive(mk(6'b000010, 3, 1, 6, 16'h0, 1, 1, 1, 0, 0, 1, 1), 1'b1);
    tick("full_sub2");
    drive('0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b0 || alu_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_stall got rdy=%b av=%b want 0 0", in_ready, alu_valid);
    end
    tick("full_hold");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("mid_reset");
    release_reset();
  endtask

  task automatic test_random();
    instr_t i;
    for (int n = 0; n < 500; n++) begin
      i = mk(6'($urandom_range(0, 63)), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), 16'($urandom), ($urandom % 8) != 0, $urandom % 2,
             $urandom % 2, 0, 0, $urandom % 2, $urandom % 2);
      if (i.op == HALT && ($urandom % 4) != 0) i.op = 6'b000001;
      case ($urandom % 4)
        0: i.wen = 1'b1;
        1: i.ren = 1'b1;
        default: ;
      endcase
      drive(i, ($urandom % 4) != 0);
      alu_ready = ($urandom % 4) != 0;
      mem_ready = ($urandom % 4) != 0;
      cdb_valid = ($urandom % 3) == 0;
      cdb_reg   = 5'($urandom_range(0, 7));
      flush     = mhalted ? (($urandom % 4) == 0) : (($urandom % 40) == 0);
      tick("random");
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_issue();
    test_raw_stall();
    test_mem_backpressure();
    test_nop_r0();
    test_halt_flush();
    test_full_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
